// File: rtl/mpc_qp_admm_pipeline_dual_row.sv
// ADMM dual-update loop: uk[i] += temp5[i] - zk[i], II=1, depth 2, with max |temp5-zk| residual.
// Optional MPC_QP_DUAL_SAT_EN clamps the written dual to the DW range instead of wrapping.
module mpc_qp_admm_pipeline_dual_row #(
    parameter int unsigned N  = 24,
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    input  logic          ap_start,
    output logic          ap_done,
    output logic          ap_idle,
    output logic          ap_ready,
    output logic [AW-1:0] zk_admm_V_address0,
    output logic          zk_admm_V_ce0,
    input  logic [DW-1:0] zk_admm_V_q0,
    output logic [AW-1:0] temp5_address0,
    output logic          temp5_ce0,
    input  logic [DW-1:0] temp5_q0,
    output logic [AW-1:0] uk_admm_V_address0,
    output logic          uk_admm_V_ce0,
    input  logic [DW-1:0] uk_admm_V_q0,
    output logic [AW-1:0] uk_admm_V_address1,
    output logic          uk_admm_V_ce1,
    output logic          uk_admm_V_we1,
    output logic [DW-1:0] uk_admm_V_d1,
    output logic [DW-1:0] res_max,
    output logic          res_max_ap_vld
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] LP_N = CW'(N);
    localparam logic [DW:0] LP_MAX = {2'b00, {(DW-1){1'b1}}};

    typedef enum logic {StIdle, StRun} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_it1;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_acc;

    logic            w_start;
    logic            w_iter0;
    logic [CW-1:0]   w_cnt;
    logic            w_exit;
    logic            w_rd;
    logic            w_rd_o;
    logic            w_wr_o;
    logic [DW:0]     w_d;
    logic [DW:0]     w_dabs;
    logic [DW-1:0]   w_dsat;
    logic [DW-1:0]   w_acc;
    logic [DW-1:0]   w_wdata;
`ifdef MPC_QP_DUAL_SAT_EN
    logic [DW+1:0]   w_s;
`endif

    // Start is taken only when both stages are empty, so a held start waits out iter1 flush.
    always_comb begin
        w_start = (r_state == StIdle) && !r_it1 && ap_start;
        w_iter0 = w_start || (r_state == StRun);
        w_cnt   = w_start ? '0 : r_cnt;
        w_exit  = w_iter0 && (w_cnt == LP_N);
        w_rd    = w_iter0 && !w_exit;
        w_rd_o  = w_rd && !ap_rst;
        w_wr_o  = r_it1 && !ap_rst;
    end

    always_comb begin
        w_d    = {temp5_q0[DW-1], temp5_q0} - {zk_admm_V_q0[DW-1], zk_admm_V_q0};
        w_dabs = w_d[DW] ? -w_d : w_d;
        w_dsat = (w_dabs > LP_MAX) ? LP_MAX[DW-1:0] : w_dabs[DW-1:0];
        w_acc  = r_acc;
        if (w_start) begin
            w_acc = '0;
        end else if (r_it1 && (w_dsat > r_acc)) begin
            w_acc = w_dsat;
        end
    end

`ifdef MPC_QP_DUAL_SAT_EN
    always_comb begin
        w_s     = {{2{uk_admm_V_q0[DW-1]}}, uk_admm_V_q0} + {w_d[DW], w_d};
        w_wdata = w_s[DW-1:0];
        if (!w_s[DW+1] && (w_s[DW:DW-1] != 2'b00)) begin
            w_wdata = {1'b0, {(DW-1){1'b1}}};
        end else if (w_s[DW+1] && (w_s[DW:DW-1] != 2'b11)) begin
            w_wdata = {1'b1, {(DW-1){1'b0}}};
        end
    end
`else
    // Low DW bits of the wide sum equal the DW-bit modular sum.
    always_comb begin
        w_wdata = uk_admm_V_q0 + w_d[DW-1:0];
    end
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_it1   <= 1'b0;
            r_waddr <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= (w_iter0 && !w_exit) ? StRun : StIdle;
            r_it1   <= w_rd;
            r_acc   <= w_acc;
            if (w_rd) begin
                r_cnt   <= w_cnt + CW'(1);
                r_waddr <= w_cnt[AW-1:0];
            end else if (w_exit) begin
                r_cnt <= '0;
            end
        end
    end

    // Outputs are gated by ap_rst so an abort takes effect in the reset cycle itself.
    always_comb begin
        zk_admm_V_ce0      = w_rd_o;
        temp5_ce0          = w_rd_o;
        uk_admm_V_ce0      = w_rd_o;
        zk_admm_V_address0 = w_rd_o ? w_cnt[AW-1:0] : '0;
        temp5_address0     = w_rd_o ? w_cnt[AW-1:0] : '0;
        uk_admm_V_address0 = w_rd_o ? w_cnt[AW-1:0] : '0;
        uk_admm_V_ce1      = w_wr_o;
        uk_admm_V_we1      = w_wr_o;
        uk_admm_V_address1 = w_wr_o ? r_waddr : '0;
        uk_admm_V_d1       = w_wr_o ? w_wdata : '0;
        ap_done            = w_exit && !ap_rst;
        ap_ready           = w_exit && !ap_rst;
        res_max_ap_vld     = w_exit && !ap_rst;
        res_max            = ap_rst ? '0 : w_acc;
        ap_idle            = ap_rst || ((r_state == StIdle) && !r_it1 && !ap_start);
    end

endmodule
